// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 inverse-cipher controller: one inverse round per round-key beat.
// Optional abort input enabled by defining AES_DEC_ABORT_EN.
module aes_dec_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
`ifdef AES_DEC_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [127:0] r_st;
    logic [127:0] r_out_data;
    logic         r_out_valid;
    logic         r_rk_req;
    logic [3:0]   r_rk_idx;
    logic         r_busy;
    logic         r_in_ready;

    logic [127:0] w_inv_sb_sr;
    logic [127:0] w_load;
    logic [127:0] w_round;
    logic [127:0] w_final;
    logic         w_abort;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as a^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] sq;
        logic [7:0] acc;
        a   = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Byte k of the block sits at packed index 15-k; state[r][c] is byte r+4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [15:0][7:0] i_b;
        logic [15:0][7:0] o_b;
        i_b = s;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o_b[15 - (r + 4 * c)] = i_b[15 - (r + 4 * ((c + 4 - r) % 4))];
            end
        end
        return o_b;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [15:0][7:0] b;
        b = s;
        for (int unsigned k = 0; k < 16; k++) begin
            b[k] = inv_sbox(b[k]);
        end
        return b;
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [15:0][7:0] i_b;
        logic [15:0][7:0] o_b;
        logic [7:0]       a0;
        logic [7:0]       a1;
        logic [7:0]       a2;
        logic [7:0]       a3;
        i_b = s;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = i_b[15 - 4 * c];
            a1 = i_b[14 - 4 * c];
            a2 = i_b[13 - 4 * c];
            a3 = i_b[12 - 4 * c];
            o_b[15 - 4 * c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o_b[14 - 4 * c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o_b[13 - 4 * c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o_b[12 - 4 * c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o_b;
    endfunction

    assign w_inv_sb_sr = inv_sub_bytes(inv_shift_rows(r_st));
    assign w_load      = r_st ^ rk_data;
    assign w_round     = inv_mix_cols(w_inv_sb_sr ^ rk_data);
    assign w_final     = w_inv_sb_sr ^ rk_data;

`ifdef AES_DEC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_rk_req    <= 1'b0;
            r_rk_idx    <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (w_abort && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_out_valid <= 1'b0;
            r_rk_req    <= 1'b0;
            r_rk_idx    <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_st       <= in_data;
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rk_req   <= 1'b1;
                        r_rk_idx   <= 4'd10;
                    end
                end
                S_LOAD: begin
                    if (rk_valid) begin
                        r_st     <= w_load;
                        r_rk_idx <= 4'd9;
                        r_state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (rk_valid) begin
                        r_st     <= w_round;
                        r_rk_idx <= r_rk_idx - 4'd1;
                        if (r_rk_idx == 4'd1) r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    if (rk_valid) begin
                        r_out_data  <= w_final;
                        r_out_valid <= 1'b1;
                        r_rk_req    <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign rk_req    = r_rk_req;
    assign rk_idx    = r_rk_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: expected plaintexts come from a forward AES-128 model
// (ciphertext = model encryption of a chosen plaintext), compared against DUT decryption.
module tb_aes_dec_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic         busy;
`ifdef AES_DEC_ABORT_EN
    logic         abort;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_sched [11];
    int           stall_cfg [11];

    int           obs_lat;
    int           obs_held_bad;
    int           obs_flag_bad;
    bit           obs_timeout;
    logic [127:0] obs_pt;
    int           obs_seq [$];

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    // Key store: serves the schedule entry addressed by the DUT.
    assign rk_data = (rk_idx <= 4'd10) ? rk_sched[rk_idx] : '0;

    aes_dec_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef AES_DEC_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic int m_mul(input int a, input int b);
        int r = 0;
        int x = a;
        int y = b;
        while (y != 0) begin
            if ((y & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return r;
    endfunction

    function automatic int m_rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 'hff;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            int s;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(x, y) == 1) inv = y;
            end
            s = inv ^ m_rotl8(inv, 1) ^ m_rotl8(inv, 2) ^ m_rotl8(inv, 3) ^ m_rotl8(inv, 4) ^ 'h63;
            sbox[x] = s[7:0];
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        int          rc = 1;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc[7:0];
                rc = m_mul(rc, 2);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_sched[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
        logic [127:0] v;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        int           a0, a1, a2, a3;
        v = pt ^ rk_sched[0];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[v[127 - 8 * k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w + 4 * c] = s[w + 4 * ((c + w) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = int'(t[4 * c]);
                    a1 = int'(t[4 * c + 1]);
                    a2 = int'(t[4 * c + 2]);
                    a3 = int'(t[4 * c + 3]);
                    t[4 * c]     = 8'(m_mul(a0, 2) ^ m_mul(a1, 3) ^ a2 ^ a3);
                    t[4 * c + 1] = 8'(a0 ^ m_mul(a1, 2) ^ m_mul(a2, 3) ^ a3);
                    t[4 * c + 2] = 8'(a0 ^ a1 ^ m_mul(a2, 2) ^ m_mul(a3, 3));
                    t[4 * c + 3] = 8'(m_mul(a0, 3) ^ a1 ^ a2 ^ m_mul(a3, 2));
                end
            end
            for (int k = 0; k < 16; k++) v[127 - 8 * k -: 8] = t[k];
            v = v ^ rk_sched[r];
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block to out_valid, serving keys with the stalls in stall_cfg.
    task automatic drive_block(input logic [127:0] ct, input bit do_accept);
        int stall_left [11];
        bit prev_stalled;
        int prev_idx;
        int idx;
        stall_left   = stall_cfg;
        obs_seq.delete();
        obs_lat      = 0;
        obs_held_bad = 0;
        obs_flag_bad = 0;
        obs_timeout  = 1'b0;
        prev_stalled = 1'b0;
        prev_idx     = 0;
        out_ready    = 1'b0;
        if (do_accept) begin
            in_valid = 1'b1;
            in_data  = ct;
            rk_valid = 1'b0;
            tick();
        end
        while (!out_valid && obs_lat < 300) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand128();
            if (in_ready || !busy) obs_flag_bad++;
            if (rk_req) begin
                idx = int'(rk_idx);
                if (prev_stalled && idx != prev_idx) obs_held_bad++;
                if (idx <= 10 && stall_left[idx] > 0) begin
                    stall_left[idx]--;
                    rk_valid     = 1'b0;
                    prev_stalled = 1'b1;
                    prev_idx     = idx;
                end else begin
                    rk_valid     = 1'b1;
                    prev_stalled = 1'b0;
                    obs_seq.push_back(idx);
                end
            end else begin
                rk_valid     = 1'($urandom_range(0, 1));
                prev_stalled = 1'b0;
            end
            tick();
            obs_lat++;
        end
        rk_valid = 1'b0;
        if (!out_valid) obs_timeout = 1'b1;
        obs_pt = out_data;
    endtask

    task automatic handshake();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rk_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef AES_DEC_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_hold_in_ready: got %0b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_hold_busy: got %0b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (rk_req !== 1'b0) begin bad++; $display("FAIL reset_rk_req: got %0b want 0", rk_req); end
        total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_vector();
        int got;
        expand_key(FIPS_KEY);
        for (int i = 0; i < 11; i++) stall_cfg[i] = 0;
        drive_block(FIPS_CT, 1'b1);
        total++; if (obs_timeout) begin bad++; $display("FAIL vector_timeout: got no out_valid want out_valid"); end
        total++; if (obs_pt !== FIPS_PT) begin bad++; $display("FAIL vector_pt: got %h want %h", obs_pt, FIPS_PT); end
        total++; if (obs_lat !== 11) begin bad++; $display("FAIL vector_latency: got %0d want 11", obs_lat); end
        total++; if (obs_flag_bad !== 0) begin bad++; $display("FAIL vector_busy_in_ready: got %0d bad cycles want 0", obs_flag_bad); end
        total++; if (obs_seq.size() !== 11) begin bad++; $display("FAIL vector_key_count: got %0d want 11", obs_seq.size()); end
        for (int i = 0; i < 11; i++) begin
            got = (i < obs_seq.size()) ? obs_seq[i] : -1;
            total++; if (got !== 10 - i) begin bad++; $display("FAIL vector_rk_idx[%0d]: got %0d want %0d", i, got, 10 - i); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL vector_no_same_cycle_ready: got %0b want 0", in_ready); end
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vector_out_valid_drop: got %0b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vector_ready_after: got %0b want 1", in_ready); end
    endtask

    task automatic test_key_stalls();
        expand_key(FIPS_KEY);
        for (int i = 0; i < 11; i++) stall_cfg[i] = 0;
        stall_cfg[10] = 3;
        stall_cfg[5]  = 3;
        stall_cfg[0]  = 3;
        drive_block(FIPS_CT, 1'b1);
        total++; if (obs_pt !== FIPS_PT) begin bad++; $display("FAIL stall_pt: got %h want %h", obs_pt, FIPS_PT); end
        total++; if (obs_lat !== 20) begin bad++; $display("FAIL stall_latency: got %0d want 20", obs_lat); end
        total++; if (obs_held_bad !== 0) begin bad++; $display("FAIL stall_idx_held: got %0d changes want 0", obs_held_bad); end
        total++; if (obs_seq.size() !== 11) begin bad++; $display("FAIL stall_key_count: got %0d want 11", obs_seq.size()); end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [127:0] pt1, pt2, ct2;
        expand_key(FIPS_KEY);
        for (int i = 0; i < 11; i++) stall_cfg[i] = 0;
        pt1 = rand128();
        pt2 = rand128();
        ct2 = m_encrypt(pt2);
        drive_block(m_encrypt(pt1), 1'b1);
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = rand128();
            rk_valid  = 1'($urandom_range(0, 1));
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, out_valid); end
            total++; if (out_data !== pt1) begin bad++; $display("FAIL bp_out_data[%0d]: got %h want %h", i, out_data, pt1); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            tick();
        end
        rk_valid  = 1'b0;
        in_valid  = 1'b1;
        in_data   = ct2;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept_at_deliver: busy got %0b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %0b want 1", in_ready); end
        drive_block(ct2, 1'b1);
        total++; if (obs_pt !== pt2) begin bad++; $display("FAIL bp_second_pt: got %h want %h", obs_pt, pt2); end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt [2];
        logic [127:0] ct [2];
        logic [127:0] got_pt [2];
        int acc_cyc [2];
        int out_cyc [2];
        int n_acc = 0;
        int n_out = 0;
        expand_key(rand128());
        for (int i = 0; i < 2; i++) begin
            pt[i] = rand128();
            ct[i] = m_encrypt(pt[i]);
            acc_cyc[i] = 0;
            out_cyc[i] = 0;
            got_pt[i]  = '0;
        end
        in_valid  = 1'b1;
        in_data   = ct[0];
        rk_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && n_out < 2; cyc++) begin
            if (in_ready && in_valid) begin acc_cyc[n_acc] = cyc; n_acc++; end
            if (out_valid) begin out_cyc[n_out] = cyc; got_pt[n_out] = out_data; n_out++; end
            tick();
            in_valid = (n_acc < 2);
            in_data  = (n_acc == 0) ? ct[0] : ct[1];
        end
        in_valid  = 1'b0;
        rk_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (n_out !== 2) begin bad++; $display("FAIL b2b_outputs: got %0d want 2", n_out); end
        for (int i = 0; i < 2; i++) begin
            total++; if (got_pt[i] !== pt[i]) begin bad++; $display("FAIL b2b_pt[%0d]: got %h want %h", i, got_pt[i], pt[i]); end
            total++; if (out_cyc[i] - acc_cyc[i] !== 12) begin bad++; $display("FAIL b2b_block_cycles[%0d]: got %0d want 12", i, out_cyc[i] - acc_cyc[i]); end
        end
        total++; if (acc_cyc[1] - out_cyc[0] !== 1) begin bad++; $display("FAIL b2b_gap: got %0d want 1", acc_cyc[1] - out_cyc[0]); end
    endtask

    task automatic test_reset_mid_block();
        logic [127:0] pt;
        int n = 0;
        expand_key(rand128());
        for (int i = 0; i < 11; i++) stall_cfg[i] = 0;
        pt = rand128();
        in_valid = 1'b1;
        in_data  = m_encrypt(pt);
        tick();
        in_valid = 1'b0;
        rk_valid = 1'b1;
        while (!(rk_req && rk_idx == 4'd6) && n < 30) begin
            tick();
            n++;
        end
        total++; if (n >= 30) begin bad++; $display("FAIL rstmid_reach_idx6: got timeout want rk_idx 6"); end
        rst_n = 1'b0;
        #1;
        total++; if (rk_req !== 1'b0) begin bad++; $display("FAIL rstmid_rk_req: got %0b want 0", rk_req); end
        total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL rstmid_rk_idx: got %0d want 0", rk_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        total++; if (dut.r_st !== '0) begin bad++; $display("FAIL rstmid_st: got %h want 0", dut.r_st); end
        rk_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (rk_req !== 1'b0) begin bad++; $display("FAIL rstmid_no_resume: got %0b want 0", rk_req); end
        pt = rand128();
        drive_block(m_encrypt(pt), 1'b1);
        total++; if (obs_pt !== pt) begin bad++; $display("FAIL rstmid_next_pt: got %h want %h", obs_pt, pt); end
        total++; if (obs_lat !== 11) begin bad++; $display("FAIL rstmid_next_latency: got %0d want 11", obs_lat); end
        handshake();
    endtask

`ifdef AES_DEC_ABORT_EN
    task automatic test_abort();
        logic [127:0] pt;
        int n = 0;
        expand_key(rand128());
        for (int i = 0; i < 11; i++) stall_cfg[i] = 0;
        pt = rand128();
        in_valid = 1'b1;
        in_data  = m_encrypt(pt);
        tick();
        in_valid = 1'b0;
        rk_valid = 1'b1;
        while (!(rk_req && rk_idx == 4'd4) && n < 30) begin
            tick();
            n++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
        total++; if (rk_req !== 1'b0) begin bad++; $display("FAIL abort_rk_req: got %0b want 0", rk_req); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %0b want 1", in_ready); end
        total++; if (dut.r_st !== '0) begin bad++; $display("FAIL abort_st: got %h want 0", dut.r_st); end
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_out_valid[%0d]: got %0b want 0", i, out_valid); end
            tick();
        end
        rk_valid = 1'b0;
        pt = rand128();
        in_valid = 1'b1;
        in_data  = m_encrypt(pt);
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_idle_accept: busy got %0b want 1", busy); end
        drive_block(in_data, 1'b0);
        total++; if (obs_pt !== pt) begin bad++; $display("FAIL abort_next_pt: got %h want %h", obs_pt, pt); end
        handshake();
    endtask
`endif

    task automatic test_random();
        logic [127:0] pt;
        int extra;
        int got;
        for (int blk = 0; blk < 8; blk++) begin
            expand_key(rand128());
            pt    = rand128();
            extra = 0;
            for (int i = 0; i < 11; i++) begin
                stall_cfg[i] = $urandom_range(0, 2);
                extra += stall_cfg[i];
            end
            drive_block(m_encrypt(pt), 1'b1);
            total++; if (obs_pt !== pt) begin bad++; $display("FAIL rand_pt[%0d]: got %h want %h", blk, obs_pt, pt); end
            total++; if (obs_lat !== 11 + extra) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", blk, obs_lat, 11 + extra); end
            total++; if (obs_held_bad !== 0) begin bad++; $display("FAIL rand_idx_held[%0d]: got %0d want 0", blk, obs_held_bad); end
            for (int i = 0; i < 11; i++) begin
                got = (i < obs_seq.size()) ? obs_seq[i] : -1;
                total++; if (got !== 10 - i) begin bad++; $display("FAIL rand_rk_idx[%0d][%0d]: got %0d want %0d", blk, i, got, 10 - i); end
            end
            repeat ($urandom_range(0, 3)) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rand_hold_valid[%0d]: got %0b want 1", blk, out_valid); end
                tick();
            end
            handshake();
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vector();
        test_key_stalls();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
`ifdef AES_DEC_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got time %0t want completion before 400000", $time);
        $fatal(1);
    end

endmodule
